uart_core: RTL

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_fifo.sv | 55 +++++
 rtl/uart_core.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared parity modes, FSM state encoding and baud divider helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int c_PARITY_NONE = 0;
  localparam int c_PARITY_ODD  = 1;
  localparam int c_PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Rounded clocks per 1/16 bit; never below one so the tick still fires.
  function automatic int calc_div(input int clk_hz, input int baud);
    int div;
    div = (clk_hz + 8 * baud) / (16 * baud);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module   : uart_fifo
// Purpose  : First-word fall-through FIFO with wrap-bit pointers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_ONE = 1;

  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_rd = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
// ============================================================================
// Module   : uart_core
// Purpose  : UART transmitter/receiver with TX/RX FIFOs and sticky errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 clear,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr_en,
  output logic                 tx_full,
  output logic                 Tx_busy,
  output logic                 Tx,
  input  logic                 Rx,
  output logic                 ready,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int              c_DIV       = calc_div(CLK_HZ, BAUD);
  localparam int              c_TW        = $clog2(c_DIV) + 1;
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
  localparam bit              c_HAS_PAR   = (PARITY != c_PARITY_NONE);
  localparam logic            c_PAR_INV   = (PARITY == c_PARITY_ODD);
  localparam logic [2:0]      c_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);

  logic [c_TW-1:0] r_tick_cnt;
  logic            w_tick;

  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) r_tick_cnt <= '0;
    else       r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  // ---------------- transmitter ----------------
  uart_state_t          r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [3:0]           r_tx_tcnt;
  logic [2:0]           r_tx_bcnt;
  logic                 r_tx_scnt;
  logic                 r_tx_par;
  logic                 r_tx_armed;
  logic                 r_tx_line;
  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_empty;
  logic                 w_tx_bit_end;
  logic                 w_tx_frame_end;
  logic                 w_tx_pop;

  assign w_tx_bit_end   = w_tick && (r_tx_tcnt == 4'd15);
  assign w_tx_frame_end = (r_tx_state == ST_STOP) && w_tx_bit_end && (r_tx_scnt == c_STOP_LAST);
  // Pop when idle and nothing is staged, or at the end of a frame to chain the next.
  assign w_tx_pop       = !w_tx_empty &&
                          (((r_tx_state == ST_IDLE) && !r_tx_armed) || w_tx_frame_end);

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk_50m),
    .rst     (clear),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .full    (tx_full),
    .rd_en   (w_tx_pop),
    .rd_data (w_tx_head),
    .empty   (w_tx_empty)
  );

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      r_tx_state <= ST_IDLE;
      r_tx_shift <= '0;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_scnt  <= 1'b0;
      r_tx_par   <= 1'b0;
      r_tx_armed <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      if (r_tx_state == ST_IDLE) r_tx_tcnt <= '0;
      else if (w_tick)           r_tx_tcnt <= r_tx_tcnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
        r_tx_par   <= (^w_tx_head) ^ c_PAR_INV;
        r_tx_armed <= 1'b1;
      end
      case (r_tx_state)
        ST_IDLE: if (r_tx_armed && w_tick) begin
          r_tx_state <= ST_START;
          r_tx_line  <= 1'b0;
          r_tx_armed <= 1'b0;
        end
        ST_START: if (w_tx_bit_end) begin
          r_tx_state <= ST_DATA;
          r_tx_line  <= r_tx_shift[0];
          r_tx_bcnt  <= '0;
        end
        ST_DATA: if (w_tx_bit_end) begin
          if (r_tx_bcnt == c_DATA_LAST) begin
            r_tx_scnt <= 1'b0;
            if (c_HAS_PAR) begin
              r_tx_state <= ST_PARITY;
              r_tx_line  <= r_tx_par;
            end else begin
              r_tx_state <= ST_STOP;
              r_tx_line  <= 1'b1;
            end
          end else begin
            r_tx_bcnt  <= r_tx_bcnt + 1'b1;
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_line  <= r_tx_shift[1];
          end
        end
        ST_PARITY: if (w_tx_bit_end) begin
          r_tx_state <= ST_STOP;
          r_tx_line  <= 1'b1;
          r_tx_scnt  <= 1'b0;
        end
        ST_STOP: if (w_tx_bit_end) begin
          if (r_tx_scnt != c_STOP_LAST) begin
            r_tx_scnt <= 1'b1;
          end else if (!w_tx_empty) begin
            r_tx_state <= ST_START;
            r_tx_line  <= 1'b0;
            r_tx_armed <= 1'b0;
          end else begin
            r_tx_state <= ST_IDLE;
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  assign Tx      = r_tx_line;
  assign Tx_busy = !w_tx_empty || r_tx_armed || (r_tx_state != ST_IDLE);

  // ---------------- receiver ----------------
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  uart_state_t          r_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [3:0]           r_rx_tcnt;
  logic [2:0]           r_rx_bcnt;
  logic                 r_rx_wait;
  logic                 r_rx_par_bad;
  logic                 r_rx_push;
  logic                 r_fe_pulse;
  logic                 r_pe_pulse;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 w_rx_bit_end;

  assign w_rx_bit_end = w_tick && (r_rx_tcnt == 4'd15);

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_state   <= ST_IDLE;
      r_rx_shift   <= '0;
      r_rx_tcnt    <= '0;
      r_rx_bcnt    <= '0;
      r_rx_wait    <= 1'b0;
      r_rx_par_bad <= 1'b0;
      r_rx_push    <= 1'b0;
      r_fe_pulse   <= 1'b0;
      r_pe_pulse   <= 1'b0;
    end else begin
      r_rx_meta  <= Rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_push  <= 1'b0;
      r_fe_pulse <= 1'b0;
      r_pe_pulse <= 1'b0;
      if (w_tick) r_rx_tcnt <= r_rx_tcnt + 1'b1;
      case (r_rx_state)
        ST_IDLE: begin
          r_rx_tcnt <= '0;
          // After a framing error the line must return high before re-arming.
          if (r_rx_sync)       r_rx_wait  <= 1'b0;
          else if (!r_rx_wait) r_rx_state <= ST_START;
        end
        ST_START: if (w_tick && (r_rx_tcnt == 4'd7)) begin
          r_rx_tcnt <= '0;
          if (r_rx_sync) begin
            r_rx_state <= ST_IDLE;
          end else begin
            r_rx_state <= ST_DATA;
            r_rx_bcnt  <= '0;
          end
        end
        ST_DATA: if (w_rx_bit_end) begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bcnt == c_DATA_LAST) r_rx_state <= c_HAS_PAR ? ST_PARITY : ST_STOP;
          else                          r_rx_bcnt  <= r_rx_bcnt + 1'b1;
        end
        ST_PARITY: if (w_rx_bit_end) begin
          r_rx_par_bad <= r_rx_sync ^ (^r_rx_shift) ^ c_PAR_INV;
          r_rx_state   <= ST_STOP;
        end
        ST_STOP: if (w_rx_bit_end) begin
          r_rx_state <= ST_IDLE;
          if (!r_rx_sync) begin
            r_fe_pulse <= 1'b1;
            r_rx_wait  <= 1'b1;
          end else if (c_HAS_PAR && r_rx_par_bad) begin
            r_pe_pulse <= 1'b1;
          end else begin
            r_rx_push <= 1'b1;
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk_50m),
    .rst     (clear),
    .wr_en   (r_rx_push),
    .wr_data (r_rx_shift),
    .full    (w_rx_full),
    .rd_en   (rd_en),
    .rd_data (data_out),
    .empty   (w_rx_empty)
  );

  assign ready = !w_rx_empty;

  // Set events take priority over err_clr.
  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (frame_err  && !err_clr) || r_fe_pulse;
      parity_err <= (parity_err && !err_clr) || r_pe_pulse;
      overrun    <= (overrun    && !err_clr) || (r_rx_push && w_rx_full && !rd_en);
    end
  end

endmodule

`default_nettype wire
